// File: rtl/am29xx_seq_slice.sv
// Am2909/Am2911-compatible 4-bit microprogram sequencer slice; cascade slices through cin/cout.
// Define AM29XX_STACK_STATUS_EN to add the stk_empty/stk_full occupancy outputs.
module am29xx_seq_slice #(
    parameter int OR_INPUTS   = 1,
    parameter int STACK_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic [3:0] rin,
    input  logic [3:0] orin,
    input  logic       s0,
    input  logic       s1,
    input  logic       zero,
    input  logic       cin,
    input  logic       re,
    input  logic       fe,
    input  logic       pup,
`ifdef AM29XX_STACK_STATUS_EN
    output logic       stk_empty,
    output logic       stk_full,
`endif
    output logic [3:0] yout,
    output logic       cout
);

    localparam int SP_W = $clog2(STACK_DEPTH);

    logic [3:0]      upc_q, upc_d;
    logic [3:0]      ar_q, ar_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [3:0]      stk_q [STACK_DEPTH];

    logic [3:0]      mux;
    logic [3:0]      or_eff;
    logic [3:0]      ar_src;
    logic [SP_W-1:0] sp_inc, sp_dec;
    logic            push, pop;

    always_comb begin
        mux = upc_q;
        case ({s1, s0})
            2'b00:   mux = upc_q;
            2'b01:   mux = ar_q;
            2'b10:   mux = stk_q[sp_q];
            default: mux = din;
        endcase
        // The Am2911 has no OR pins and loads its address register from the direct bus.
        or_eff = (OR_INPUTS != 0) ? orin : 4'h0;
        ar_src = (OR_INPUTS != 0) ? rin : din;

        yout = (mux | or_eff) & {4{zero}};
        cout = cin & (yout == 4'hF);

        push   = ~fe & pup;
        pop    = ~fe & ~pup;
        sp_inc = sp_q + SP_W'(1);
        sp_dec = sp_q - SP_W'(1);

        upc_d = yout + {3'b000, cin};
        ar_d  = re ? ar_src : ar_q;
        sp_d  = sp_q;
        if (push) begin
            sp_d = sp_inc;
        end else if (pop) begin
            sp_d = sp_dec;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            upc_q <= 4'h0;
            ar_q  <= 4'h0;
            sp_q  <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_q[i] <= 4'h0;
            end
        end else begin
            upc_q <= upc_d;
            ar_q  <= ar_d;
            sp_q  <= sp_d;
            // Push stores the return address: the uPC before this edge's update.
            if (push) begin
                stk_q[sp_inc] <= upc_q;
            end
        end
    end

`ifdef AM29XX_STACK_STATUS_EN
    localparam int OCC_W = $clog2(STACK_DEPTH + 1);

    logic [OCC_W-1:0] occ_q, occ_d;

    function automatic logic [OCC_W-1:0] occ_step(input logic [OCC_W-1:0] occ,
                                                  input logic inc, input logic dec);
        logic [OCC_W-1:0] r;
        r = occ;
        if (inc && occ != OCC_W'(STACK_DEPTH)) begin
            r = occ + OCC_W'(1);
        end else if (dec && occ != '0) begin
            r = occ - OCC_W'(1);
        end
        return r;
    endfunction

    always_comb begin
        occ_d = occ_step(occ_q, push, pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign stk_empty = (occ_q == '0);
    assign stk_full  = (occ_q == OCC_W'(STACK_DEPTH));
`endif

endmodule

// File: tb/tb_am29xx_seq_slice.sv
// Randomized and directed bench for am29xx_seq_slice: an Am2909 and an Am2911 instance
// share stimulus and are each compared against an array-based behavioural model.
module tb_am29xx_seq_slice;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] din, rin, orin;
    logic       s0, s1, zero, cin, re, fe, pup;
    logic [3:0] y0, y1;
    logic       c0, c1;
`ifdef AM29XX_STACK_STATUS_EN
    logic       e0, f0, e1, f1;
`endif

    always #5 clock = ~clock;

    am29xx_seq_slice #(.OR_INPUTS(1), .STACK_DEPTH(DEPTH)) u_dut (
        .clock(clock), .reset(reset), .din(din), .rin(rin), .orin(orin),
        .s0(s0), .s1(s1), .zero(zero), .cin(cin), .re(re), .fe(fe), .pup(pup),
`ifdef AM29XX_STACK_STATUS_EN
        .stk_empty(e0), .stk_full(f0),
`endif
        .yout(y0), .cout(c0)
    );

    am29xx_seq_slice #(.OR_INPUTS(0), .STACK_DEPTH(DEPTH)) u_dut11 (
        .clock(clock), .reset(reset), .din(din), .rin(rin), .orin(orin),
        .s0(s0), .s1(s1), .zero(zero), .cin(cin), .re(re), .fe(fe), .pup(pup),
`ifdef AM29XX_STACK_STATUS_EN
        .stk_empty(e1), .stk_full(f1),
`endif
        .yout(y1), .cout(c1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state, index 0 = Am2909 instance, 1 = Am2911 instance.
    int m_upc [2];
    int m_ar  [2];
    int m_sp  [2];
    int m_occ [2];
    int m_stk [2][DEPTH];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int m_y(input int k);
        int src;
        int sel;
        sel = (s1 ? 2 : 0) + (s0 ? 1 : 0);
        case (sel)
            0: src = m_upc[k];
            1: src = m_ar[k];
            2: src = m_stk[k][m_sp[k]];
            default: src = int'(din);
        endcase
        if (k == 0) src = src | int'(orin);
        return zero ? src : 0;
    endfunction

    function automatic int m_cout(input int k);
        return (cin && m_y(k) == 15) ? 1 : 0;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int y;
            int old_upc;
            if (reset) begin
                m_upc[k] = 0; m_ar[k] = 0; m_sp[k] = 0; m_occ[k] = 0;
                for (int j = 0; j < DEPTH; j++) m_stk[k][j] = 0;
            end else begin
                y = m_y(k);
                old_upc = m_upc[k];
                m_upc[k] = (y + int'(cin)) % 16;
                if (re) m_ar[k] = (k == 0) ? int'(rin) : int'(din);
                if (!fe) begin
                    if (pup) begin
                        m_sp[k] = (m_sp[k] + 1) % DEPTH;
                        m_stk[k][m_sp[k]] = old_upc;
                        if (m_occ[k] < DEPTH) m_occ[k]++;
                    end else begin
                        m_sp[k] = (m_sp[k] + DEPTH - 1) % DEPTH;
                        if (m_occ[k] > 0) m_occ[k]--;
                    end
                end
            end
        end
    endtask

    // Let combinational outputs settle mid-cycle and compare against the model.
    task automatic settle();
        #2;
        check("y2909", int'(y0), m_y(0));
        check("c2909", int'(c0), m_cout(0));
        check("y2911", int'(y1), m_y(1));
        check("c2911", int'(c1), m_cout(1));
`ifdef AM29XX_STACK_STATUS_EN
        check("empty2909", int'(e0), (m_occ[0] == 0) ? 1 : 0);
        check("full2909",  int'(f0), (m_occ[0] == DEPTH) ? 1 : 0);
        check("empty2911", int'(e1), (m_occ[1] == 0) ? 1 : 0);
        check("full2911",  int'(f1), (m_occ[1] == DEPTH) ? 1 : 0);
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic drive(input int s, input int d, input int r, input int o,
                         input int z, input int ci, input int rev, input int fev, input int pu);
        reset = 1'b0;
        s1 = s[1]; s0 = s[0];
        din = d[3:0]; rin = r[3:0]; orin = o[3:0];
        zero = z[0]; cin = ci[0]; re = rev[0]; fe = fev[0]; pup = pu[0];
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 1, 1, 0, 1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 1, 1, 0, 1, 0);
        reset = 1'b1;
        @(posedge clock);
        model_edge();
        #1;

        // Reset then count: 0..15 then wrap to 0, cout only at 15.
        drive(0, 0, 0, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 17; i++) begin
            settle();
            check("run_y", int'(y0), i % 16);
            check("run_cout", int'(c0), (i % 16 == 15) ? 1 : 0);
            tick();
        end

        // Direct source with OR mask.
        drive(3, 8, 0, 3, 1, 1, 0, 1, 0);
        settle();
        check("dir_or", int'(y0), 11);
        check("dir_or_2911", int'(y1), 8);
        tick();
        drive(0, 0, 0, 0, 1, 1, 0, 1, 0);
        settle();
        check("after_dir", int'(y0), 12);
        tick();

        // Address register load.
        drive(0, 9, 5, 0, 1, 1, 1, 1, 0);
        settle();
        tick();
        drive(1, 0, 0, 0, 1, 1, 0, 1, 0);
        settle();
        check("ar_2909", int'(y0), 5);
        check("ar_2911", int'(y1), 9);
        tick();
        drive(1, 0, 0, 15, 1, 1, 0, 1, 0);
        settle();
        check("ar_or_2911", int'(y1), 9);
        tick();

        // Same-cycle AR load and AR select shows the old value.
        drive(1, 3, 7, 0, 1, 0, 1, 1, 0);
        settle();
        check("ar_old", int'(y0), 5);
        tick();
        drive(1, 0, 0, 0, 1, 0, 0, 1, 0);
        settle();
        check("ar_new", int'(y0), 7);
        tick();

        // Push return address 6, jump away, pop it back.
        drive(3, 5, 0, 0, 1, 1, 0, 1, 0);
        settle();
        tick();
        drive(3, 2, 0, 0, 1, 1, 0, 0, 1);
        settle();
        check("jump", int'(y0), 2);
        tick();
        drive(2, 0, 0, 0, 1, 1, 0, 0, 0);
        settle();
        check("pop_ret", int'(y0), 6);
        check("pop_ret_2911", int'(y1), 6);
        tick();

        // Stack wrap: five pushes of 1..5 into four words, then four pops.
        do_reset();
        drive(3, 0, 0, 0, 1, 1, 0, 1, 0);
        settle();
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 1, 0, 0, 1);
            settle();
            check("push_upc", int'(y0), i + 1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(2, 0, 0, 0, 1, 0, 0, 0, 0);
            settle();
            check("wrap_pop", int'(y0), 5 - i);
            tick();
        end
        drive(0, 0, 0, 0, 1, 0, 0, 1, 0);
        settle();
        tick();

        // zero override.
        drive(3, 15, 0, 0, 0, 1, 0, 1, 0);
        settle();
        check("zero_y", int'(y0), 0);
        check("zero_cout", int'(c0), 0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0, 1, 0);
        settle();
        check("zero_upc", int'(y0), 1);
        tick();
        drive(3, 15, 0, 0, 1, 1, 0, 1, 0);
        settle();
        check("cout_f", int'(c0), 1);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0,
                  ($urandom_range(0, 7) == 0) ? 0 : 1,
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            if ($urandom_range(0, 49) == 0) reset = 1'b1;
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
